// File: rtl/uart_link_arbiter_pkg.sv
// Shared definitions for the UART link arbiter and bus bridge slave: frame layout helpers,
// FSM state encoding and fixed timing constants.
package uart_link_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StTxStart,
    StTxWait,
    StRwait,
    StResp
  } state_e;

  // Cycles TXSTART waits for the transmitter to report busy before moving on.
  localparam int unsigned TxStartCycles = 4;

  // Frame layout: {mode, wdata, addr}, mode 1 = write.
  function automatic int unsigned frame_width(input int unsigned data_w,
                                              input int unsigned addr_w);
    return data_w + addr_w + 1;
  endfunction

  function automatic int unsigned mode_bit(input int unsigned data_w,
                                           input int unsigned addr_w);
    return data_w + addr_w;
  endfunction

  function automatic int unsigned wdata_lsb(input int unsigned addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant register advances only when a grant is taken.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);

  logic last_q;

  always_comb begin
    grant_idx_o = 1'b0;
    unique case (req_i)
      2'b01:   grant_idx_o = 1'b0;
      2'b10:   grant_idx_o = 1'b1;
      2'b11:   grant_idx_o = ~last_q;
      default: grant_idx_o = 1'b0;
    endcase
    grant_o = (req_i == 2'b00) ? 2'b00 : (grant_idx_o ? 2'b10 : 2'b01);
  end

  // Reset to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (update_i && (req_i != 2'b00)) begin
      last_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/uart_link_arbiter.sv
// Arbitrates two bus requesters onto one UART link: sends a frame, waits for TX to finish,
// and for reads waits (with timeout) for the reply byte.
module uart_link_arbiter
  import uart_link_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RD_TIMEOUT = 65535,
  localparam int unsigned F = frame_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [2*F-1:0]        req_frame,
  output logic [1:0]            req_ready,
  output logic [1:0]            done,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [F-1:0]          u_din,
  output logic                  u_en,
  input  logic                  u_tx_busy,
  input  logic                  u_rx_ready,
  input  logic [DATA_WIDTH-1:0] u_dout,
  output logic                  busy
);

  localparam int unsigned ModeBit = mode_bit(DATA_WIDTH, ADDR_WIDTH);
  localparam int unsigned CntW = ($clog2(RD_TIMEOUT + 1) > 2) ? $clog2(RD_TIMEOUT + 1) : 2;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(RD_TIMEOUT - 1);
  localparam logic [CntW-1:0] TxStartLast = CntW'(TxStartCycles - 1);

  state_e                state_q, state_d;
  logic [F-1:0]          u_din_q, u_din_d;
  logic                  g_q, g_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            done_q, done_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [1:0]            req_ready_c;
  logic                  u_en_c;
  logic [1:0]            grant;
  logic                  grant_idx;
  logic                  arb_en;

  assign arb_en = (state_q == StIdle);

  rr_arbiter2 u_arb (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req_valid),
    .update_i    (arb_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    u_din_d     = u_din_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    done_d      = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_c = 2'b00;
    u_en_c      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid != 2'b00) begin
          req_ready_c = grant;
          g_d         = grant_idx;
          u_din_d     = grant_idx ? req_frame[2*F-1:F] : req_frame[F-1:0];
          state_d     = StLoad;
        end
      end
      StLoad: begin
        u_en_c  = 1'b1;
        cnt_d   = '0;
        state_d = StTxStart;
      end
      StTxStart: begin
        if (u_tx_busy || (cnt_q == TxStartLast)) begin
          state_d = StTxWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StTxWait: begin
        if (!u_tx_busy) begin
          if (u_din_q[ModeBit]) begin
            done_d    = g_q ? 2'b10 : 2'b01;
            rsp_err_d = 1'b0;
            state_d   = StIdle;
          end else begin
            cnt_d   = '0;
            state_d = StRwait;
          end
        end
      end
      StRwait: begin
        // A byte arriving on the timeout cycle still counts as a good reply.
        if (u_rx_ready) begin
          rsp_data_d = u_dout;
          rsp_err_d  = 1'b0;
          done_d     = g_q ? 2'b10 : 2'b01;
          state_d    = StResp;
        end else if (cnt_q == TimeoutLast) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          done_d     = g_q ? 2'b10 : 2'b01;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      u_din_q    <= '0;
      g_q        <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 2'b00;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      u_din_q    <= u_din_d;
      g_q        <= g_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // done and the response fields update on the same edge, so they are valid together.
  assign done      = done_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign u_din     = u_din_q;
  assign req_ready = rst ? 2'b00 : req_ready_c;
  assign u_en      = rst ? 1'b0 : u_en_c;
  assign busy      = !rst && (state_q != StIdle);

endmodule
